if_id_hazard_reg: RTL and testbench
===================================

Name: if_id_hazard_reg

Overview:
- IF/ID pipeline register and hazard control. It sits on the consuming side of the fetch stage.
- Latches the fetched instruction and PC+4 and returns the held instruction as instructionID. While stalled, the fetch stage re-presents that instruction.
- Generates the load-use stall request back to fetch.
- Squashes wrong-path instructions when a branch resolves taken in MEM.
- Keeps saturating stall and flush event counters for debug.

Parameters:
- CNT_W, 16, width of the stall and flush event counters.
- NOP_INSTR, 32'h00000000, encoding inserted as a bubble.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low (asserted when 0).
- instructionIF  in  32  instruction from the fetch stage.
- PCplus4IF  in  32  PC+4 from the fetch stage.
- PCSrcMEM  in  1  branch or jump resolved taken in MEM.
- MemReadEX  in  1  instruction in EX is a load.
- rtEX  in  5  destination register of the load in EX.
- instructionID  out  32  registered instruction for decode; also fed back to fetch.
- PCplus4ID  out  32  registered PC+4 for decode.
- validID  out  1  instructionID is a real, non-squashed instruction.
- stall  out  1  hold PC and IF/ID (combinational).
- flushIDEX  out  1  force a bubble into ID/EX next edge (combinational).
- flushEXMEM  out  1  force a bubble into EX/MEM next edge (combinational).
- stallCount  out  CNT_W  saturating count of stall cycles.
- flushCount  out  CNT_W  saturating count of taken redirects.

Behaviour:
- Reset (reset=0, asynchronous):
  - instructionID=NOP_INSTR, PCplus4ID=0, validID=0.
  - Both counters 0; state=RUN.
  - Combinational outputs evaluate to 0.
- Source-use decode of instructionID:
  - rs is used unless opcode is 6'h02 or 6'h03 or the instruction equals NOP_INSTR.
  - rt is used for opcode 6'h00 (excluding NOP_INSTR), 6'h04, 6'h05, 6'h2B.
- Hazard detection:
  - hazard = validID & MemReadEX & (rtEX!=0) & ((rs used & rs==rtEX) | (rt used & rt==rtEX)).
- Priority: PCSrcMEM overrides hazard.
  - If PCSrcMEM=1: stall=0, flushIDEX=1, flushEXMEM=1.
  - Else if hazard: stall=1, flushIDEX=1, flushEXMEM=0.
  - Else: all three 0.
- Register update on each rising edge:
  - PCSrcMEM=1: load NOP_INSTR, PCplus4ID unchanged, validID=0.
  - Else stall=1: hold all three registers.
  - Else: load instructionIF and PCplus4IF, validID=1.
- FSM with states RUN, LOAD_STALL, REDIRECT:
  - RUN -> LOAD_STALL when stall=1.
  - Any state -> REDIRECT when PCSrcMEM=1.
  - LOAD_STALL -> RUN when the hazard clears. This normally takes 1 cycle, because the load advances to MEM.
  - LOAD_STALL -> LOAD_STALL if the hazard is still present (back-to-back loads into the same register).
  - REDIRECT -> RUN after exactly one cycle, unless PCSrcMEM=1 again, in which case it stays in REDIRECT.
  - In REDIRECT, validID=0 is guaranteed. The hazard term is masked by validID, so no stall is raised for the squashed slot.
- Counters:
  - stallCount increments each cycle stall=1.
  - flushCount increments on each cycle entering REDIRECT.
  - Both saturate at all-ones with no wrap.
- Reset asserted mid-stall or mid-redirect returns immediately to the reset values. No pending state survives.
- Latency: 1 cycle from IF to ID. A stall adds exactly one cycle per hazard cycle.

Decomposition:
- Shared package (mips_pkg): opcode constants (OP_RTYPE=6'h00, OP_J=6'h02, OP_JAL=6'h03, OP_BEQ=6'h04, OP_BNE=6'h05, OP_SW=6'h2B), NOP_INSTR, and the FSM state enum.
- One natural sub-module: hazard_detect. It is purely combinational: it takes instructionID, validID, MemReadEX and rtEX, and outputs hazard.
- The register file, FSM and counters stay in the top module.

Test Plan:
- Reset release, instructionIF=32'h20080005, PCplus4IF=4 -> after one edge: instructionID=32'h20080005, PCplus4ID=4, validID=1, stall=0.
- Load-use (rs hit):
  - Setup: ID holds add $10,$8,$9 (32'h01095020); MemReadEX=1, rtEX=8.
  - Required response: stall=1, flushIDEX=1, ID held for 1 edge, stallCount=1.
  - On the next cycle, with MemReadEX=0: stall=0 and ID advances.
- Load-use suppression:
  - rtEX=0 with MemReadEX=1 -> no stall.
  - ID holds addi with rt==rtEX (rt not used as source) -> no stall.
- Branch flush with simultaneous hazard (PCSrcMEM=1 and hazard both true) -> stall=0, flushIDEX=1, flushEXMEM=1; next edge instructionID=0, validID=0, flushCount=1; after one more edge, state=RUN.
- Back-to-back PCSrcMEM on two consecutive cycles -> flushCount=2, validID=0 for both, state stays REDIRECT for 2 cycles.
- Counter saturation with CNT_W=2: 5 consecutive stall cycles -> stallCount=3 held. Assert reset=0 mid-stall -> counters=0, validID=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: opcode constants, bubble encoding and
// the IF/ID control state type.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    REDIRECT   = 2'd2
  } state_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection for the instruction held in ID against a load in EX.
// Purely combinational.
module hazard_detect #(
  parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
  input  logic [31:0] instruction,
  input  logic        valid,
  input  logic        mem_read,
  input  logic [4:0]  rt_ex,
  output logic        hazard
);
  import mips_pkg::*;

  logic [5:0] opcode;
  logic [4:0] rs;
  logic [4:0] rt;
  logic       is_nop;
  logic       rs_used;
  logic       rt_used;

  assign opcode = instruction[31:26];
  assign rs     = instruction[25:21];
  assign rt     = instruction[20:16];
  assign is_nop = (instruction == NOP_INSTR);

  // Jumps carry no register sources; rt is a source only for R-type, branches and stores.
  assign rs_used = !((opcode == OP_J) || (opcode == OP_JAL) || is_nop);
  assign rt_used = ((opcode == OP_RTYPE) && !is_nop) || (opcode == OP_BEQ) ||
                   (opcode == OP_BNE) || (opcode == OP_SW);

  assign hazard = valid && mem_read && (rt_ex != 5'd0) &&
                  ((rs_used && (rs == rt_ex)) || (rt_used && (rt == rt_ex)));

endmodule

// File: rtl/if_id_hazard_reg.sv
// IF/ID pipeline register with load-use stall, taken-branch squash and
// saturating debug counters.
//
//   state      | meaning
//   RUN        | normal flow, IF/ID loads every cycle
//   LOAD_STALL | IF/ID held while a load in EX feeds the instruction in ID
//   REDIRECT   | ID slot squashed after a taken branch/jump in MEM
module if_id_hazard_reg #(
  parameter int          CNT_W     = 16,
  parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instructionIF,
  input  logic [31:0]      PCplus4IF,
  input  logic             PCSrcMEM,
  input  logic             MemReadEX,
  input  logic [4:0]       rtEX,
  output logic [31:0]      instructionID,
  output logic [31:0]      PCplus4ID,
  output logic             validID,
  output logic             stall,
  output logic             flushIDEX,
  output logic             flushEXMEM,
  output logic [CNT_W-1:0] stallCount,
  output logic [CNT_W-1:0] flushCount
);
  import mips_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic   hazard;
  state_t state;
  state_t state_nxt;

  hazard_detect #(
    .NOP_INSTR (NOP_INSTR)
  ) u_hazard_detect (
    .instruction (instructionID),
    .valid       (validID),
    .mem_read    (MemReadEX),
    .rt_ex       (rtEX),
    .hazard      (hazard)
  );

  // A taken redirect outranks the load-use stall; the squashed slot must not stall.
  always_comb begin
    stall      = 1'b0;
    flushIDEX  = 1'b0;
    flushEXMEM = 1'b0;
    if (reset) begin
      if (PCSrcMEM) begin
        flushIDEX  = 1'b1;
        flushEXMEM = 1'b1;
      end else if (hazard) begin
        stall     = 1'b1;
        flushIDEX = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    if (PCSrcMEM) begin
      state_nxt = REDIRECT;
    end else begin
      case (state)
        RUN:        state_nxt = stall ? LOAD_STALL : RUN;
        LOAD_STALL: state_nxt = stall ? LOAD_STALL : RUN;
        REDIRECT:   state_nxt = RUN;
        default:    state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instructionID <= NOP_INSTR;
      PCplus4ID     <= 32'd0;
      validID       <= 1'b0;
    end else if (PCSrcMEM) begin
      instructionID <= NOP_INSTR;
      validID       <= 1'b0;
    end else if (!stall) begin
      instructionID <= instructionIF;
      PCplus4ID     <= PCplus4IF;
      validID       <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stallCount <= '0;
      flushCount <= '0;
    end else begin
      if (stall && (stallCount != CNT_MAX)) begin
        stallCount <= stallCount + 1'b1;
      end
      if (PCSrcMEM && (flushCount != CNT_MAX)) begin
        flushCount <= flushCount + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_if_id_hazard_reg.sv
// Self-checking bench for if_id_hazard_reg: directed scenarios followed by
// randomized traffic compared against a behavioural pipeline model.
module tb_if_id_hazard_reg;
  import mips_pkg::*;

  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [31:0]      instructionIF = 32'd0;
  logic [31:0]      PCplus4IF = 32'd0;
  logic             PCSrcMEM = 1'b0;
  logic             MemReadEX = 1'b0;
  logic [4:0]       rtEX = 5'd0;
  logic [31:0]      instructionID;
  logic [31:0]      PCplus4ID;
  logic             validID;
  logic             stall;
  logic             flushIDEX;
  logic             flushEXMEM;
  logic [CNT_W-1:0] stallCount;
  logic [CNT_W-1:0] flushCount;

  if_id_hazard_reg #(.CNT_W(CNT_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .instructionIF (instructionIF),
    .PCplus4IF     (PCplus4IF),
    .PCSrcMEM      (PCSrcMEM),
    .MemReadEX     (MemReadEX),
    .rtEX          (rtEX),
    .instructionID (instructionID),
    .PCplus4ID     (PCplus4ID),
    .validID       (validID),
    .stall         (stall),
    .flushIDEX     (flushIDEX),
    .flushEXMEM    (flushEXMEM),
    .stallCount    (stallCount),
    .flushCount    (flushCount)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model of the architecturally visible state.
  logic [31:0] m_instr;
  logic [31:0] m_pc;
  bit          m_valid;
  int          m_scnt;
  int          m_fcnt;
  state_t      m_state;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit model_hazard(input logic [31:0] ins, input bit valid,
                                      input bit mr, input logic [4:0] rt_ex);
    int op;
    int rs;
    int rt;
    bit rs_used;
    bit rt_used;
    op = int'(ins[31:26]);
    rs = int'(ins[25:21]);
    rt = int'(ins[20:16]);
    if (!valid || !mr || rt_ex == 5'd0) return 1'b0;
    rs_used = !(op == 2 || op == 3 || ins == NOP_INSTR);
    rt_used = (op == 0 && ins != NOP_INSTR) || op == 4 || op == 5 || op == 'h2B;
    return (rs_used && rs == int'(rt_ex)) || (rt_used && rt == int'(rt_ex));
  endfunction

  task automatic model_reset();
    m_instr = NOP_INSTR;
    m_pc    = 32'd0;
    m_valid = 1'b0;
    m_scnt  = 0;
    m_fcnt  = 0;
    m_state = RUN;
  endtask

  task automatic check_regs(input string ctx);
    chk({ctx, ".instructionID"}, instructionID, m_instr);
    chk({ctx, ".PCplus4ID"}, PCplus4ID, m_pc);
    chk({ctx, ".validID"}, 32'(validID), 32'(m_valid));
    chk({ctx, ".stallCount"}, 32'(stallCount), 32'(m_scnt));
    chk({ctx, ".flushCount"}, 32'(flushCount), 32'(m_fcnt));
    chk({ctx, ".state"}, 32'(dut.state), 32'(m_state));
  endtask

  // Called 1 time unit after a rising edge; returns 1 time unit after the next one.
  task automatic step(input logic [31:0] ins, input logic [31:0] pc4, input bit pcs,
                      input bit mr, input logic [4:0] rt_ex);
    bit h;
    bit e_stall;
    instructionIF = ins;
    PCplus4IF     = pc4;
    PCSrcMEM      = pcs;
    MemReadEX     = mr;
    rtEX          = rt_ex;
    #3;
    h       = model_hazard(m_instr, m_valid, mr, rt_ex);
    e_stall = !pcs && h;
    chk("stall", 32'(stall), 32'(e_stall));
    chk("flushIDEX", 32'(flushIDEX), 32'(pcs || h));
    chk("flushEXMEM", 32'(flushEXMEM), 32'(pcs));
    @(posedge clk);
    if (e_stall && m_scnt < CMAX) m_scnt++;
    if (pcs && m_fcnt < CMAX) m_fcnt++;
    if (pcs) begin
      m_instr = NOP_INSTR;
      m_valid = 1'b0;
      m_state = REDIRECT;
    end else if (e_stall) begin
      m_state = LOAD_STALL;
    end else begin
      m_instr = ins;
      m_pc    = pc4;
      m_valid = 1'b1;
      m_state = RUN;
    end
    #1;
    check_regs("step");
  endtask

  task automatic check_reset_values(input string ctx);
    chk({ctx, ".instructionID"}, instructionID, NOP_INSTR);
    chk({ctx, ".PCplus4ID"}, PCplus4ID, 32'd0);
    chk({ctx, ".validID"}, 32'(validID), 32'd0);
    chk({ctx, ".stallCount"}, 32'(stallCount), 32'd0);
    chk({ctx, ".flushCount"}, 32'(flushCount), 32'd0);
    chk({ctx, ".stall"}, 32'(stall), 32'd0);
    chk({ctx, ".flushIDEX"}, 32'(flushIDEX), 32'd0);
    chk({ctx, ".flushEXMEM"}, 32'(flushEXMEM), 32'd0);
  endtask

  // Pulse reset between edges, check asynchronously, release and resync.
  task automatic pulse_reset();
    #1;
    reset = 1'b0;
    #1;
    model_reset();
    check_reset_values("async_reset");
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] ops [8];
    logic [31:0] ins;
    ops = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h2B, 6'h08, 6'h23};
    if ($urandom_range(0, 9) == 0) return NOP_INSTR;
    ins = $urandom;
    ins[31:26] = ops[$urandom_range(0, 7)];
    ins[25:21] = 5'($urandom_range(0, 7));
    ins[20:16] = 5'($urandom_range(0, 7));
    return ins;
  endfunction

  localparam logic [31:0] ADD_I  = 32'h01095020;
  localparam logic [31:0] ADDI_I = 32'h21280005;

  initial begin
    model_reset();
    #12;
    check_reset_values("reset");
    chk("reset.state", 32'(dut.state), 32'(RUN));
    @(posedge clk);
    #1;
    reset = 1'b1;

    step(32'h20080005, 32'd4, 0, 0, 5'd0);
    chk("first.instructionID", instructionID, 32'h20080005);
    chk("first.PCplus4ID", PCplus4ID, 32'd4);
    chk("first.validID", 32'(validID), 32'd1);

    // Load-use on rs, then hazard clears.
    step(ADD_I, 32'd8, 0, 0, 5'd0);
    step(32'h8C0B0000, 32'd12, 0, 1, 5'd8);
    chk("loaduse.held", instructionID, ADD_I);
    chk("loaduse.stallCount", 32'(stallCount), 32'd1);
    step(32'h8C0B0000, 32'd12, 0, 0, 5'd8);
    chk("loaduse.advance", instructionID, 32'h8C0B0000);

    // Suppression: rtEX zero, and addi whose rt is a destination only.
    step(ADD_I, 32'd16, 0, 0, 5'd0);
    step(ADDI_I, 32'd20, 0, 1, 5'd0);
    chk("rtex0.instructionID", instructionID, ADDI_I);
    step(32'h00000020, 32'd24, 0, 1, 5'd8);
    chk("addi_rt.stallCount", 32'(stallCount), 32'd1);

    // Taken branch with a simultaneous load-use hazard.
    step(ADD_I, 32'd28, 0, 0, 5'd0);
    step(32'h11111111, 32'd32, 1, 1, 5'd8);
    chk("branch.instructionID", instructionID, 32'd0);
    chk("branch.flushCount", 32'(flushCount), 32'd1);
    step(32'h00000020, 32'd36, 0, 0, 5'd0);
    chk("branch.state_run", 32'(dut.state), 32'(RUN));

    // Back-to-back redirects from a clean counter state.
    pulse_reset();
    step(ADD_I, 32'd40, 1, 0, 5'd0);
    chk("b2b1.state", 32'(dut.state), 32'(REDIRECT));
    step(ADD_I, 32'd44, 1, 1, 5'd9);
    chk("b2b2.flushCount", 32'(flushCount), 32'd2);
    chk("b2b2.validID", 32'(validID), 32'd0);
    chk("b2b2.state", 32'(dut.state), 32'(REDIRECT));
    step(ADD_I, 32'd48, 0, 0, 5'd0);

    // Stall counter saturation, then reset in the middle of the stall.
    for (int i = 0; i < 5; i++) step(32'h8C0B0000, 32'd52, 0, 1, 5'd9);
    chk("sat.stallCount", 32'(stallCount), 32'd3);
    chk("sat.state", 32'(dut.state), 32'(LOAD_STALL));
    pulse_reset();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        pulse_reset();
      end else begin
        step(rand_instr(), $urandom & 32'hFFFF_FFFC, ($urandom_range(0, 6) == 0),
             ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
